// File: rtl/memory_stage_pkg.sv
// memory_stage shared opcodes, state encodings and decode helpers.
// MS_SUBWORD_EN adds byte/half loads and stores to the memory op set.
package memory_stage_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 5;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam logic [0:0] MS_IDLE = 1'b0;
  localparam logic [0:0] MS_WAIT = 1'b1;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [AWIDTH-1:0]       rd;
  } ms_txn_t;

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
`ifdef MS_SUBWORD_EN
    return op inside {OP_LW, OP_SW, OP_LB, OP_LBU,
                      OP_LH, OP_LHU, OP_SB, OP_SH};
`else
    return (op == OP_LW) || (op == OP_SW);
`endif
  endfunction

  function automatic logic is_store(
    input logic [5:0] op
  );
    return op inside {OP_SW, OP_SB, OP_SH};
  endfunction

  function automatic logic is_misaligned(
    input logic [5:0] op,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == OP_LW) || (op == OP_SW): r = (off != 2'b00);
      op inside {OP_LH, OP_LHU, OP_SH}: r = off[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack port between memory_stage and the memory.
// Request fields are held stable while mem_req is high.
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_stage_mem_align.sv
// Byte-lane helper: store be/replication and load extract/extend.
// Only instantiated when MS_SUBWORD_EN is defined.
module memory_stage_mem_align
  import memory_stage_pkg::*;
(
  input  logic [5:0]        st_op,
  input  logic [1:0]        st_off,
  input  logic [DWIDTH-1:0] st_data,
  input  logic [5:0]        ld_op,
  input  logic [1:0]        ld_off,
  input  logic [DWIDTH-1:0] ld_raw,
  output logic [3:0]        be,
  output logic [DWIDTH-1:0] st_lanes,
  output logic [DWIDTH-1:0] ld_data
);

  logic [DWIDTH-1:0] sh;

  always_comb begin
    be       = 4'hF;
    st_lanes = st_data;
    unique case (1'b1)
      st_op == OP_SB: begin
        be       = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      st_op == OP_SH: begin
        be       = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh      = ld_raw >> {ld_off, 3'b000};
    ld_data = ld_raw;
    unique case (1'b1)
      ld_op == OP_LB:  ld_data = {{24{sh[7]}}, sh[7:0]};
      ld_op == OP_LBU: ld_data = {24'd0, sh[7:0]};
      ld_op == OP_LH:  ld_data = {{16{sh[15]}}, sh[15:0]};
      ld_op == OP_LHU: ld_data = {16'd0, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: retires ALU ops, runs LW/SW over req/ack.
// MS_SUBWORD_EN enables LB/LBU/LH/LHU/SB/SH via memory_stage_mem_align.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    ms_i_clk,
  input  logic                    ms_i_rst,
  input  logic                    ms_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_data_rt,
  input  logic [AWIDTH-1:0]       ms_i_addr_rd,
  output logic                    ms_o_stall,
  memory_stage_if.master          mem,
  output logic                    ms_o_ce,
  output logic                    ms_o_reg_we,
  output logic [DWIDTH-1:0]       ms_o_wb_data,
  output logic [AWIDTH-1:0]       ms_o_addr_rd,
  output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic                    ms_o_misalign,
  output logic                    ms_o_timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ?
    $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  ms_txn_t           txn;
  logic              op_mem;
  logic              op_mis;
  logic              expire;
  logic [3:0]        be_next;
  logic [DWIDTH-1:0] wdata_next;
  logic [DWIDTH-1:0] ld_data;

  assign op_mem = is_mem_op(ms_i_opcode);
  assign op_mis = op_mem &&
    is_misaligned(ms_i_opcode, ms_i_alu_value[1:0]);
  assign expire = (MEM_TIMEOUT != 0) && (cnt == CNT_LAST);
  assign ms_o_stall = (state == MS_WAIT);

`ifdef MS_SUBWORD_EN
  logic [1:0] ld_off;

  always_ff @(posedge ms_i_clk or posedge ms_i_rst) begin
    if (ms_i_rst)
      ld_off <= 2'b00;
    else if (state == MS_IDLE && ms_i_ce)
      ld_off <= ms_i_alu_value[1:0];
  end

  memory_stage_mem_align u_align (
    .st_op    (ms_i_opcode),
    .st_off   (ms_i_alu_value[1:0]),
    .st_data  (ms_i_data_rt),
    .ld_op    (txn.opcode),
    .ld_off   (ld_off),
    .ld_raw   (mem.mem_rdata),
    .be       (be_next),
    .st_lanes (wdata_next),
    .ld_data  (ld_data)
  );
`else
  assign be_next    = 4'hF;
  assign wdata_next = ms_i_data_rt;
  assign ld_data    = mem.mem_rdata;
`endif

  always_ff @(posedge ms_i_clk or posedge ms_i_rst) begin
    if (ms_i_rst) begin
      state         <= MS_IDLE;
      cnt           <= '0;
      txn           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= 4'h0;
      ms_o_ce       <= 1'b0;
      ms_o_reg_we   <= 1'b0;
      ms_o_wb_data  <= '0;
      ms_o_addr_rd  <= '0;
      ms_o_opcode   <= '0;
      ms_o_misalign <= 1'b0;
      ms_o_timeout  <= 1'b0;
    end else begin
      ms_o_ce       <= 1'b0;
      ms_o_misalign <= 1'b0;
      unique case (state)
        MS_IDLE: begin
          if (ms_i_ce && op_mem && !op_mis) begin
            state         <= MS_WAIT;
            cnt           <= '0;
            txn.opcode    <= ms_i_opcode;
            txn.rd        <= ms_i_addr_rd;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store(ms_i_opcode);
            mem.mem_addr  <= {ms_i_alu_value[31:2], 2'b00};
            mem.mem_wdata <= wdata_next;
            mem.mem_be    <= be_next;
          end else if (ms_i_ce) begin
            ms_o_ce      <= 1'b1;
            ms_o_opcode  <= ms_i_opcode;
            ms_o_addr_rd <= ms_i_addr_rd;
            if (op_mis) begin
              ms_o_reg_we   <= 1'b0;
              ms_o_wb_data  <= '0;
              ms_o_misalign <= 1'b1;
            end else begin
              ms_o_reg_we  <= (ms_i_addr_rd != '0);
              ms_o_wb_data <= ms_i_alu_value;
            end
          end
        end
        MS_WAIT: begin
          // an ack arriving on the expiry cycle still completes normally
          if (mem.mem_ack || expire) begin
            state        <= MS_IDLE;
            mem.mem_req  <= 1'b0;
            ms_o_ce      <= 1'b1;
            ms_o_opcode  <= txn.opcode;
            ms_o_addr_rd <= txn.rd;
            ms_o_reg_we  <= 1'b0;
            ms_o_wb_data <= '0;
            if (!mem.mem_ack) begin
              ms_o_timeout <= 1'b1;
            end else if (!is_store(txn.opcode)) begin
              ms_o_reg_we  <= (txn.rd != '0);
              ms_o_wb_data <= ld_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage (MEM_TIMEOUT=4).
// Reference model computes results from opcode/lane rules directly.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [5:0]  opcode;
  logic [31:0] alu;
  logic [31:0] rt;
  logic [4:0]  rd;
  logic        stall;
  logic        o_ce;
  logic        reg_we;
  logic [31:0] wb;
  logic [4:0]  o_rd;
  logic [5:0]  o_op;
  logic        mis;
  logic        tout;

  memory_stage_if mif ();

  memory_stage #(.MEM_TIMEOUT(TO)) dut (
    .ms_i_clk       (clk),
    .ms_i_rst       (rst),
    .ms_i_ce        (ce),
    .ms_i_opcode    (opcode),
    .ms_i_alu_value (alu),
    .ms_i_data_rt   (rt),
    .ms_i_addr_rd   (rd),
    .ms_o_stall     (stall),
    .mem            (mif),
    .ms_o_ce        (o_ce),
    .ms_o_reg_we    (reg_we),
    .ms_o_wb_data   (wb),
    .ms_o_addr_rd   (o_rd),
    .ms_o_opcode    (o_op),
    .ms_o_misalign  (mis),
    .ms_o_timeout   (tout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_to   = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic bit m_is_mem(input logic [5:0] op);
`ifdef MS_SUBWORD_EN
    return op == OP_LW || op == OP_SW || op == OP_LB ||
           op == OP_LBU || op == OP_LH || op == OP_LHU ||
           op == OP_SB || op == OP_SH;
`else
    return op == OP_LW || op == OP_SW;
`endif
  endfunction

  function automatic int m_size(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit m_store(input logic [5:0] op);
    return op == OP_SW || op == OP_SB || op == OP_SH;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op,
                                      input int off);
    int s;
    s = m_size(op);
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op,
                                          input logic [31:0] d);
    int s;
    s = m_size(op);
    if (s == 1) return {4{d[7:0]}};
    if (s == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op,
                                         input int off,
                                         input logic [31:0] r);
    int v;
    v = int'(r >> (8 * off));
    if (op == OP_LBU) return 32'(v & 255);
    if (op == OP_LHU) return 32'(v & 65535);
    if (op == OP_LB) begin
      v = v & 255;
      return 32'((v >= 128) ? v - 256 : v);
    end
    if (op == OP_LH) begin
      v = v & 65535;
      return 32'((v >= 32768) ? v - 65536 : v);
    end
    return r;
  endfunction

  task automatic do_op(input logic [5:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [4:0]  r,
                       input logic [31:0] rdv,
                       input int          delay);
    bit is_mem;
    bit bad;
    bit done;
    bit acked;
    int off;
    int sz;
    logic [31:0] ewb;
    off = int'(a[1:0]);
    sz  = m_size(op);
    is_mem = m_is_mem(op);
    bad = is_mem && ((off % sz) != 0);
    @(negedge clk);
    check("idle_ce", {31'd0, o_ce}, 32'd0);
    ce = 1'b1; opcode = op; alu = a; rt = d; rd = r;
    @(posedge clk);
    #1;
    ce = 1'b0; opcode = 6'($urandom);
    alu = $urandom; rt = $urandom; rd = 5'($urandom);
    if (!is_mem || bad) begin
      @(negedge clk);
      check("ret_ce", {31'd0, o_ce}, 32'd1);
      check("ret_we", {31'd0, reg_we},
            {31'd0, !bad && r != 0});
      if (!bad) check("ret_wb", wb, a);
      check("ret_mis", {31'd0, mis}, {31'd0, bad});
      check("ret_rd", {27'd0, o_rd}, {27'd0, r});
      check("ret_op", {26'd0, o_op}, {26'd0, op});
      check("no_req", {31'd0, mif.mem_req}, 32'd0);
      check("no_stall", {31'd0, stall}, 32'd0);
    end else begin
      done = 1'b0;
      acked = 1'b0;
      for (int k = 1; k <= TO + 1 && !done; k++) begin
        @(negedge clk);
        check("req", {31'd0, mif.mem_req}, 32'd1);
        check("stall", {31'd0, stall}, 32'd1);
        check("wait_ce", {31'd0, o_ce}, 32'd0);
        check("addr", mif.mem_addr, {a[31:2], 2'b00});
        check("we", {31'd0, mif.mem_we},
              {31'd0, m_store(op)});
        check("be", {28'd0, mif.mem_be},
              {28'd0, m_be(op, off)});
        if (m_store(op))
          check("wdata", mif.mem_wdata, m_wdata(op, d));
        if (k == delay) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = rdv;
          acked = 1'b1;
        end
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = $urandom;
        if (acked || k == TO) done = 1'b1;
      end
      if (!done) check("wait_bound", 32'd0, 32'd1);
      @(negedge clk);
      if (!acked) exp_to = 1'b1;
      ewb = (acked && !m_store(op)) ?
            m_load(op, off, rdv) : 32'd0;
      check("mret_ce", {31'd0, o_ce}, 32'd1);
      check("mret_req", {31'd0, mif.mem_req}, 32'd0);
      check("mret_stall", {31'd0, stall}, 32'd0);
      check("mret_we", {31'd0, reg_we},
            {31'd0, acked && !m_store(op) && r != 0});
      if (acked && !m_store(op))
        check("mret_wb", wb, ewb);
      check("mret_rd", {27'd0, o_rd}, {27'd0, r});
      check("mret_op", {26'd0, o_op}, {26'd0, op});
      check("mret_mis", {31'd0, mis}, 32'd0);
    end
    check("timeout", {31'd0, tout}, {31'd0, exp_to});
  endtask

  logic [5:0] ops [11];

  initial begin
    ops = '{6'h00, 6'h0C, 6'h01, OP_LW, OP_SW, OP_LB,
            OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH};
    rst = 1'b1; ce = 1'b0; opcode = '0; alu = '0;
    rt = '0; rd = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    #12;
    check("rst_req", {31'd0, mif.mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ce", {31'd0, o_ce}, 32'd0);
    check("rst_out", {wb[31:1], reg_we}, 32'd0);
    check("rst_misc", {20'd0, o_rd, o_op, tout},
          32'd0);
    check("rst_addr", mif.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(6'h00, 32'h1234, 32'h0, 5'd5, 32'h0, 1);
    do_op(OP_LW, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 3);
    do_op(OP_SW, 32'h104, 32'hA5A5A5A5, 5'd3, 32'h0, 1);
    do_op(OP_LW, 32'h102, 32'h0, 5'd9, 32'h0, 1);
    do_op(OP_LW, 32'h200, 32'h0, 5'd4, 32'h13572468, TO);
    do_op(OP_LW, 32'h204, 32'h0, 5'd4, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(op, a, $urandom, 5'($urandom), $urandom,
            $urandom_range(0, 5));
    end

    @(negedge clk);
    ce = 1'b1; opcode = OP_LW; alu = 32'h300; rd = 5'd2;
    @(posedge clk);
    #1 ce = 1'b0;
    @(negedge clk);
    check("mid_req", {31'd0, mif.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, mif.mem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_to", {31'd0, tout}, 32'd0);
    exp_to = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ce", {31'd0, o_ce}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(OP_LB, 32'h103, 32'h0, 5'd6, 32'h80123456, 1);
    do_op(6'h00, 32'h55, 32'h0, 5'd0, 32'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
